jericalla_evo_datapath: RTL and testbench
=========================================

// Module: jericalla_evo_datapath
// PURPOSE
//  3-stage pipelined 32-bit datapath: decode, register read, ALU/memory, writeback.
//  - Consumes one 17-bit instruction per clock.
//  - Executes ADD, SUB and MIN on a 32x32 register file, and stores words to a data memory.
//  - Internally composed of: control decode, register file, ALU, two pipeline buffers and a memory unit.
//  - Top-level compute core. The instruction is driven directly by the surrounding sequencer; there is no fetch.
// PARAMETERS
//  DATA_W     32   datapath, register and memory word width
//  RF_ADDR_W  5    register address width (32 registers)
//  MEM_AW     8    memory word-index width (256 words)
// PORTS
//  clock        in   1   single clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  instruction  in   17  [16:15] opcode, [14:10] rd, [9:5] rs1, [4:0] rs2
//  output_data  out  32  registered result of the most recently retired instruction
// BEHAVIOUR
//  Reset and clocking: one clock; reset is asynchronous and active-low.
//  Opcodes:
//   00 ADD: R[rd] <= R[rs1] + R[rs2], modulo 2^32, carry discarded.
//   01 SUB: R[rd] <= R[rs1] - R[rs2], modulo 2^32, borrow discarded.
//   10 MIN: R[rd] <= (R[rs1] < R[rs2], unsigned) ? R[rs1] : R[rs2].
//   11 SW:  mem[R[rs1][MEM_AW-1:0]] <= R[rs2]. No register write; rd is ignored.
//  Control word (8 bits, decoded combinationally from opcode):
//   bit0 = reg write, [4:1] = ALU op (0000 add, 0001 sub, 0010 min), bit5 = addr-path select,
//   bit6 = mem write, bit7 = mem read. Unused ALU op codes produce 0.
//  Pipeline:
//   S0 (comb): decode opcode; read R[rs1] and R[rs2] asynchronously.
//   Edge 1, buffer 1: latches operand A, operand B, rd, control word, valid=1.
//   S1 (comb): if sel=0, A feeds the ALU; if sel=1, A is routed to the memory address path.
//   Edge 2, buffer 2: latches ALU result, address, store data (operand B), rd, control, valid.
//   Edge 3 (retire): if reg write, R[rd] <= result; if mem write, mem[addr] <= store data.
//    output_data <= result for ALU ops, or store data for SW.
//  Latency: 3 rising edges from instruction presentation to architectural update.
//   Throughput is 1 instruction per clock.
//  Hazards: no stall and no forwarding. An instruction reads the register file in S0.
//   The register file is write-first: a same-cycle retire to the register being read is visible.
//   Reads of registers written by either of the two older in-flight instructions return stale data.
//  R0 is an ordinary writable register (not hardwired to zero).
//  Holding the same instruction for N cycles issues it N times; each copy retires independently.
//  Memory: word-addressed, 256 x 32. Address bits [31:MEM_AW] are ignored (wrap-around).
//   Synchronous write; combinational read.
//  Reset (reset_n=0, async):
//   - both buffers cleared: valid=0, control=0, data=0;
//   - output_data=0;
//   - the in-flight instructions are squashed, so no register or memory write occurs.
//  Reset contents: register file (array named "registers") and memory (array named "mem") are
//   not reset. Both must be preloadable by backdoor $readmemb.
//  First valid retire after reset release occurs on the 3rd rising edge after release.
// TESTING
//  T1 ADD: preload R0=5, R1=3; issue 00_00100_00000_00001 for 1 cycle
//      -> after 3 edges R4=8 and output_data=8.
//  T2 SUB wrap: R1=3, R2=10; issue 01_00101_00001_00010
//      -> R5=0xFFFFFFF9 and output_data=0xFFFFFFF9.
//  T3 MIN: R2=10, R3=7; issue 10_00110_00010_00011 -> R6=7.
//      Swap values (R2=7, R3=10) -> R6=7.
//  T4 SW: R7=0x100, R4=8; issue 11_00000_00111_00100
//      -> mem[0x00]=8 (address wraps), no register changes, output_data=8.
//  T5 back-to-back: ADD R4=R0+R1, then next cycle ADD R8=R4+R4
//      -> R8 uses the stale R4, per the no-forwarding rule.
//  T6 reset: assert reset_n=0 between edge 1 and edge 2 of an ADD
//      -> output_data=0 immediately, and R[rd] stays unchanged after release.

Source files
------------

// File: rtl/jericalla_evo_datapath.sv
// 3-stage pipelined 32-bit compute core: ADD/SUB/MIN on a 32x32 register file and word
// stores to a 256x32 data memory. No stalls, no forwarding; the register file is write-first.
module jericalla_evo_datapath #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 5,
  parameter int MEM_AW    = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [2+3*RF_ADDR_W-1:0]   instruction,
  output logic [DATA_W-1:0]          output_data
);

  localparam int INSTR_W   = 2 + 3 * RF_ADDR_W;
  localparam int RF_DEPTH  = 1 << RF_ADDR_W;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MIN = 2'b10,
    OP_SW  = 2'b11
  } opcode_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MIN = 4'd2;

  // Control word, MSB first: bit7 mem_rd .. bit0 reg_wr.
  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic [3:0] alu_op;
    logic       reg_wr;
  } ctrl_t;

  typedef struct packed {
    logic                 valid;
    ctrl_t                ctrl;
    logic [RF_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
  } buf1_t;

  typedef struct packed {
    logic                 valid;
    ctrl_t                ctrl;
    logic [RF_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]    result;
    logic [MEM_AW-1:0]    addr;
    logic [DATA_W-1:0]    store;
  } buf2_t;

  logic [DATA_W-1:0] registers [RF_DEPTH];
  logic [DATA_W-1:0] mem       [MEM_DEPTH];

  buf1_t b1_d, b1_q;
  buf2_t b2_d, b2_q;
  logic [DATA_W-1:0] out_d, out_q;

  opcode_e              opcode;
  logic [RF_ADDR_W-1:0] rd, rs1, rs2;
  ctrl_t                ctrl_dec;
  logic [DATA_W-1:0]    rs1_data, rs2_data;
  logic [DATA_W-1:0]    alu_a, alu_y;
  logic [MEM_AW-1:0]    mem_addr;
  logic                 wb_reg_we, wb_mem_we;

  assign opcode = opcode_e'(instruction[INSTR_W-1 -: 2]);
  assign rd     = instruction[3*RF_ADDR_W-1 -: RF_ADDR_W];
  assign rs1    = instruction[2*RF_ADDR_W-1 -: RF_ADDR_W];
  assign rs2    = instruction[RF_ADDR_W-1:0];

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    ctrl_dec = '0;
    case (opcode)
      OP_ADD: begin ctrl_dec.reg_wr = 1'b1; ctrl_dec.alu_op = ALU_ADD; end
      OP_SUB: begin ctrl_dec.reg_wr = 1'b1; ctrl_dec.alu_op = ALU_SUB; end
      OP_MIN: begin ctrl_dec.reg_wr = 1'b1; ctrl_dec.alu_op = ALU_MIN; end
      OP_SW:  begin ctrl_dec.addr_sel = 1'b1; ctrl_dec.mem_wr = 1'b1; end
      default: ctrl_dec = '0;
    endcase
  end

  assign wb_reg_we = b2_q.valid & b2_q.ctrl.reg_wr;
  assign wb_mem_we = b2_q.valid & b2_q.ctrl.mem_wr;

  // Write-first: a retire landing this cycle on a register being read is bypassed into S0.
  assign rs1_data = (wb_reg_we && (b2_q.rd == rs1)) ? b2_q.result : registers[rs1];
  assign rs2_data = (wb_reg_we && (b2_q.rd == rs2)) ? b2_q.result : registers[rs2];

  always_comb begin
    b1_d       = '0;
    b1_d.valid = 1'b1;
    b1_d.ctrl  = ctrl_dec;
    b1_d.rd    = rd;
    b1_d.a     = rs1_data;
    b1_d.b     = rs2_data;
  end

  // S1: operand A goes either to the ALU or to the memory address path.
  assign alu_a    = b1_q.ctrl.addr_sel ? '0 : b1_q.a;
  assign mem_addr = b1_q.ctrl.addr_sel ? b1_q.a[MEM_AW-1:0] : '0;

  always_comb begin
    alu_y = '0;
    case (b1_q.ctrl.alu_op)
      ALU_ADD: alu_y = alu_a + b1_q.b;
      ALU_SUB: alu_y = alu_a - b1_q.b;
      ALU_MIN: alu_y = (alu_a < b1_q.b) ? alu_a : b1_q.b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    b2_d        = '0;
    b2_d.valid  = b1_q.valid;
    b2_d.ctrl   = b1_q.ctrl;
    b2_d.rd     = b1_q.rd;
    b2_d.result = alu_y;
    b2_d.addr   = mem_addr;
    b2_d.store  = b1_q.b;
  end

  always_comb begin
    out_d = out_q;
    if (b2_q.valid) begin
      if (b2_q.ctrl.mem_wr)      out_d = b2_q.store;
      else if (b2_q.ctrl.mem_rd) out_d = mem[b2_q.addr];
      else                       out_d = b2_q.result;
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b1_q  <= '0;
      b2_q  <= '0;
      out_q <= '0;
    end else begin
      b1_q  <= b1_d;
      b2_q  <= b2_d;
      out_q <= out_d;
    end
  end

  // NOTE: storage arrays carry no reset; squashing happens through the cleared valid bits.
  always_ff @(posedge clock) begin
    if (wb_reg_we) registers[b2_q.rd] <= b2_q.result;
    if (wb_mem_we) mem[b2_q.addr]     <= b2_q.store;
  end

  assign output_data = out_q;

  logic unused_b2_ctrl;
  assign unused_b2_ctrl = ^{b2_q.ctrl.addr_sel, b2_q.ctrl.alu_op};

endmodule

// File: tb/tb_jericalla_evo_datapath.sv
// Scoreboard bench for jericalla_evo_datapath: directed instructions push hand-computed
// retire results; a negedge monitor pops and compares output_data, registers and memory.
module tb_jericalla_evo_datapath;

  logic        clock;
  logic        reset_n;
  logic [16:0] instruction;
  logic [31:0] output_data;

  jericalla_evo_datapath dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instruction (instruction),
    .output_data (output_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int ecount = 0;
  always @(posedge clock) ecount <= ecount + 1;

  typedef struct {
    int          due;
    string       name;
    logic [31:0] out;
    bit          chk_reg;
    int          reg_idx;
    logic [31:0] reg_val;
    bit          chk_mem;
    int          mem_idx;
    logic [31:0] mem_val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [16:0] IDLE = {2'b00, 5'd31, 5'd30, 5'd30};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] enc(input logic [1:0] op, input int rd, input int rs1,
                                      input int rs2);
    return {op, rd[4:0], rs1[4:0], rs2[4:0]};
  endfunction

  task automatic drive(input logic [16:0] instr);
    @(posedge clock);
    #1;
    instruction = instr;
  endtask

  task automatic issue(input string name, input logic [16:0] instr, input logic [31:0] out,
                       input bit chk_reg, input int ri, input logic [31:0] rv,
                       input bit chk_mem, input int mi, input logic [31:0] mv);
    exp_t e;
    drive(instr);
    e.due = ecount + 3; e.name = name; e.out = out;
    e.chk_reg = chk_reg; e.reg_idx = ri; e.reg_val = rv;
    e.chk_mem = chk_mem; e.mem_idx = mi; e.mem_val = mv;
    sb_q.push_back(e);
  endtask

  task automatic idle_push();
    issue("idle", IDLE, 32'h0, 1'b1, 31, 32'h0, 1'b0, 0, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].due <= ecount) begin
      e = sb_q.pop_front();
      check({e.name, " retire slot"}, ecount, e.due);
      check({e.name, " output_data"}, output_data, e.out);
      if (e.chk_reg) check({e.name, " reg"}, dut.registers[e.reg_idx], e.reg_val);
      if (e.chk_mem) check({e.name, " mem"}, dut.mem[e.mem_idx], e.mem_val);
    end
  end

  initial begin
    reset_n     = 1'b0;
    instruction = IDLE;
    #3;
    check("reset output_data", output_data, 32'h0);
    check("reset b1 valid", dut.b1_q.valid, 1'b0);
    check("reset b2 valid", dut.b2_q.valid, 1'b0);

    for (int i = 0; i < 32; i++) dut.registers[i] = 32'h0;
    dut.registers[0]  = 32'd5;
    dut.registers[1]  = 32'd3;
    dut.registers[2]  = 32'd10;
    dut.registers[3]  = 32'd7;
    dut.registers[4]  = 32'h11;
    dut.registers[5]  = 32'h5555;
    dut.registers[6]  = 32'h66;
    dut.registers[7]  = 32'h100;
    dut.registers[11] = 32'h8000_0000;
    dut.registers[12] = 32'd1;
    dut.registers[13] = 32'hAB;
    dut.registers[14] = 32'hFFFF_FFFF;
    dut.registers[15] = 32'h1FF;
    dut.registers[16] = 32'h1234_5678;
    dut.registers[18] = 32'h77;
    dut.registers[20] = 32'h99;
    dut.registers[21] = 32'h21;
    for (int i = 0; i < 256; i++) dut.mem[i] = 32'h0;
    dut.mem[0]    = 32'hAAAA;
    dut.mem[8'hFF] = 32'hBBBB;

    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Back-to-back stream; hazards resolved by hand (stale in S0, write-first at retire).
    issue("T1 add",        17'b00_00100_00000_00001, 32'd8,        1, 4,  32'd8,        0, 0, 0);
    issue("T5 stale",      enc(2'b00, 8, 4, 4),      32'h22,       1, 8,  32'h22,       0, 0, 0);
    issue("write-first",   enc(2'b00, 9, 4, 0),      32'd13,       1, 9,  32'd13,       0, 0, 0);
    issue("T2 sub wrap",   17'b01_00101_00001_00010, 32'hFFFF_FFF9, 1, 5, 32'hFFFF_FFF9, 0, 0, 0);
    issue("T3 min",        17'b10_00110_00010_00011, 32'd7,        1, 6,  32'd7,        0, 0, 0);
    issue("T4 sw",         17'b11_00000_00111_00100, 32'd8,        1, 0,  32'd5,        1, 0, 32'd8);
    issue("min unsigned",  enc(2'b10, 13, 11, 12),   32'd1,        1, 13, 32'd1,        0, 0, 0);
    issue("add carry",     enc(2'b00, 14, 14, 12),   32'h0,        1, 14, 32'h0,        0, 0, 0);
    issue("sw wrap ff",    enc(2'b11, 0, 15, 16),    32'h1234_5678, 1, 0, 32'd5,       1, 255, 32'h1234_5678);
    issue("hold copy1",    enc(2'b00, 17, 17, 12),   32'd1,        1, 17, 32'd1,        0, 0, 0);
    issue("hold copy2",    enc(2'b00, 17, 17, 12),   32'd1,        1, 17, 32'd1,        0, 0, 0);
    issue("hold copy3",    enc(2'b00, 17, 17, 12),   32'd2,        1, 17, 32'd2,        0, 0, 0);
    repeat (3) idle_push();
    drain();

    @(posedge clock);
    #1;
    dut.registers[2] = 32'd7;
    dut.registers[3] = 32'd10;
    dut.registers[6] = 32'h66;
    issue("T3 min swap",   17'b10_00110_00010_00011, 32'd7,        1, 6,  32'd7,        0, 0, 0);
    repeat (3) idle_push();
    drain();

    // Reset squash: X retires just before reset, Z and Y are in flight and must vanish.
    drive(enc(2'b00, 19, 0, 1));
    drive(enc(2'b00, 20, 0, 0));
    drive(enc(2'b00, 18, 0, 1));
    @(posedge clock);
    #1;
    check("T6 pre-reset output", output_data, 32'd8);
    instruction = IDLE;
    reset_n = 1'b0;
    #1;
    check("T6 async clear output", output_data, 32'h0);
    check("T6 async clear b1", dut.b1_q.valid, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    instruction = enc(2'b00, 21, 0, 1);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    instruction = IDLE;
    @(posedge clock);
    #1;
    check("release edge2 output", output_data, 32'h0);
    check("release edge2 R21", dut.registers[21], 32'h21);
    @(posedge clock);
    #1;
    check("release edge3 output", output_data, 32'd8);
    check("release edge3 R21", dut.registers[21], 32'd8);
    check("T6 squashed R18", dut.registers[18], 32'h77);
    check("T6 squashed R20", dut.registers[20], 32'h99);
    check("T6 retired R19", dut.registers[19], 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
